// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART-side constants: byte width, default FIFO depth, TX FSM encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_tx_fifo_pkg;

    localparam int BYTE_W        = 8;
    localparam int DEFAULT_DEPTH = 16;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SEND      = 3'd1,
        S_WAIT_ACT  = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_GAP       = 3'd4
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Byte FIFO: DEPTH x 8 storage, wrapping pointers, separate occupancy count.
// Latency: a write is visible at the head and in count one cycle after it is accepted.
// Backpressure: writes while full are dropped and flagged by a one-cycle overflow pulse; a same-cycle pop never frees room.
module sync_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter  int DEPTH  = DEFAULT_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] wr_dat,
    input  logic              rd_en,
    output logic [BYTE_W-1:0] rd_dat,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_ok;
    logic              rd_ok;

    // Flags come from the registered count only, so full is judged before any pop this cycle.
    assign full   = (count == DEPTH_CNT);
    assign empty  = (count == '0);
    assign wr_ok  = wr_en && !full;
    assign rd_ok  = rd_en && !empty;
    assign rd_dat = mem[rd_ptr];

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointer, count and overflow bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= wr_en && full;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte queue in front of a uart_tx: launches one frame per queued byte, in write order.
// Latency: accepted write into an empty idle queue -> o_Tx_DV two cycles later.
// Backpressure: waits for uart_tx idle/done plus one gap cycle per frame; writes while full are dropped with o_Overflow.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter  int DEPTH  = DEFAULT_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
)(
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Wr_En,
    input  logic [BYTE_W-1:0] i_Wr_Byte,
    output logic              o_Full,
    output logic              o_Empty,
    output logic [ADDR_W:0]   o_Count,
    output logic              o_Overflow,
    output logic              o_Tx_DV,
    output logic [BYTE_W-1:0] o_Tx_Byte,
    input  logic              i_Tx_Active,
    input  logic              i_Tx_Done
);

    tx_state_t         state;
    logic              pop;
    logic [BYTE_W-1:0] head;

    // The head is consumed in the single S_SEND cycle, while o_Tx_DV is high.
    assign pop = (state == S_SEND);

    sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (i_Clock),
        .rst      (i_Reset),
        .wr_en    (i_Wr_En),
        .wr_dat   (i_Wr_Byte),
        .rd_en    (pop),
        .rd_dat   (head),
        .full     (o_Full),
        .empty    (o_Empty),
        .count    (o_Count),
        .overflow (o_Overflow)
    );

    // Frame launch FSM with registered start strobe and held byte.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state     <= S_IDLE;
            o_Tx_DV   <= 1'b0;
            o_Tx_Byte <= '0;
        end else begin
            o_Tx_DV <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!o_Empty && !i_Tx_Active) begin
                        state     <= S_SEND;
                        o_Tx_DV   <= 1'b1;
                        o_Tx_Byte <= head;
                    end
                end
                S_SEND: begin
                    state <= S_WAIT_ACT;
                end
                S_WAIT_ACT: begin
                    // A very short frame may finish before active is ever seen.
                    if (i_Tx_Done) begin
                        state <= S_GAP;
                    end else if (i_Tx_Active) begin
                        state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (i_Tx_Done) begin
                        state <= S_GAP;
                    end
                end
                S_GAP: begin
                    // Skips the cycle uart_tx spends cleaning up after done.
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a behavioural uart_tx frame responder.
// Latency: n/a.
// Backpressure: the responder holds i_Tx_Active for FRAME_CYC cycles per frame, or permanently while busy_hold is set.
module tb_uart_tx_fifo;

    localparam int FRAME_CYC = 20;

    logic       i_Clock;
    logic       i_Reset;
    logic       i_Wr_En;
    logic [7:0] i_Wr_Byte;
    logic       o_Full;
    logic       o_Empty;
    logic [4:0] o_Count;
    logic       o_Overflow;
    logic       o_Tx_DV;
    logic [7:0] o_Tx_Byte;
    logic       i_Tx_Active;
    logic       i_Tx_Done;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         dv_cnt = 0;
    int         ovf_cnt = 0;
    int         last_done_edge = 0;
    logic       busy_hold = 1'b0;
    logic [7:0] rx_q [$];
    int         gap_q [$];

    uart_tx_fifo #(
        .DEPTH (16)
    ) dut (
        .i_Clock     (i_Clock),
        .i_Reset     (i_Reset),
        .i_Wr_En     (i_Wr_En),
        .i_Wr_Byte   (i_Wr_Byte),
        .o_Full      (o_Full),
        .o_Empty     (o_Empty),
        .o_Count     (o_Count),
        .o_Overflow  (o_Overflow),
        .o_Tx_DV     (o_Tx_DV),
        .o_Tx_Byte   (o_Tx_Byte),
        .i_Tx_Active (i_Tx_Active),
        .i_Tx_Done   (i_Tx_Done)
    );

    initial begin
        i_Clock = 1'b0;
        forever #5 i_Clock = ~i_Clock;
    end

    always @(posedge i_Clock) cyc <= cyc + 1;

    // Count overflow pulses.
    initial begin
        forever begin
            @(posedge i_Clock); #1;
            if (o_Overflow === 1'b1) ovf_cnt++;
        end
    end

    // uart_tx stand-in: captures the byte on each start strobe, then runs a frame.
    initial begin
        i_Tx_Active = 1'b0;
        i_Tx_Done   = 1'b0;
        forever begin
            @(posedge i_Clock); #1;
            if (o_Tx_DV === 1'b1) begin
                rx_q.push_back(o_Tx_Byte);
                dv_cnt++;
                gap_q.push_back(cyc - last_done_edge);
                i_Tx_Active = 1'b1;
                repeat (FRAME_CYC) begin
                    @(posedge i_Clock); #1;
                end
                i_Tx_Active = 1'b0;
                i_Tx_Done   = 1'b1;
                last_done_edge = cyc + 1;
                @(posedge i_Clock); #1;
                i_Tx_Done = 1'b0;
            end else begin
                i_Tx_Active = busy_hold;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rx(input int n, input string tag);
        int budget;
        budget = (n - rx_q.size()) * (FRAME_CYC + 10) + 50;
        while (rx_q.size() < n && budget > 0) begin
            @(negedge i_Clock);
            budget--;
        end
        check(tag, rx_q.size(), n);
    endtask

    task automatic settle();
        repeat (FRAME_CYC + 10) @(negedge i_Clock);
    endtask

    task automatic write_burst(input logic [7:0] first, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge i_Clock);
            i_Wr_En   = 1'b1;
            i_Wr_Byte = first + 8'(k);
        end
        @(negedge i_Clock);
        i_Wr_En = 1'b0;
    endtask

    initial begin
        int base;
        int gbase;
        int dv_base;
        int ovf_base;
        int wait_budget;

        i_Reset   = 1'b0;
        i_Wr_En   = 1'b0;
        i_Wr_Byte = 8'h00;
        #2 i_Reset = 1'b1;
        #10;
        // reset state
        check("rst_dv",    o_Tx_DV,    1'b0);
        check("rst_byte",  o_Tx_Byte,  8'h00);
        check("rst_ovf",   o_Overflow, 1'b0);
        check("rst_empty", o_Empty,    1'b1);
        check("rst_full",  o_Full,     1'b0);
        check("rst_count", o_Count,    5'd0);
        repeat (3) @(negedge i_Clock);
        i_Reset = 1'b0;
        while ($time < 95) @(negedge i_Clock);

        // V1: single byte, two-cycle latency
        base = rx_q.size();
        @(negedge i_Clock);
        i_Wr_En = 1'b1; i_Wr_Byte = 8'h0A;
        @(posedge i_Clock); #1;
        i_Wr_En = 1'b0;
        check("v1_count1", o_Count, 5'd1);
        check("v1_nempty", o_Empty, 1'b0);
        check("v1_dv_c1",  o_Tx_DV, 1'b0);
        @(posedge i_Clock); #1;
        check("v1_dv_c2",  o_Tx_DV,   1'b1);
        check("v1_byte",   o_Tx_Byte, 8'h0A);
        @(posedge i_Clock); #1;
        check("v1_dv_off", o_Tx_DV,   1'b0);
        check("v1_hold",   o_Tx_Byte, 8'h0A);
        check("v1_popped", o_Count,   5'd0);
        wait_rx(base + 1, "v1_rx_n");
        check("v1_rx", rx_q[base], 8'h0A);
        settle();

        // V2: burst of three, concurrent write+pop, gap timing
        base = rx_q.size(); gbase = gap_q.size(); dv_base = dv_cnt;
        @(negedge i_Clock); i_Wr_En = 1'b1; i_Wr_Byte = 8'h2D;
        @(negedge i_Clock); i_Wr_Byte = 8'h55;
        check("v2_count_a", o_Count, 5'd1);
        @(negedge i_Clock); i_Wr_Byte = 8'hAA;
        check("v2_count_b", o_Count, 5'd2);
        check("v2_dv",      o_Tx_DV, 1'b1);
        check("v2_byte0",   o_Tx_Byte, 8'h2D);
        @(negedge i_Clock); i_Wr_En = 1'b0;
        check("v2_wr_pop",  o_Count, 5'd2);
        wait_rx(base + 3, "v2_rx_n");
        check("v2_rx0", rx_q[base],     8'h2D);
        check("v2_rx1", rx_q[base + 1], 8'h55);
        check("v2_rx2", rx_q[base + 2], 8'hAA);
        settle();
        check("v2_dv_cnt", dv_cnt - dv_base, 3);
        check("v2_gap1", gap_q[gbase + 1], 2);
        check("v2_gap2", gap_q[gbase + 2], 2);

        // V3: 17 writes with uart_tx busy
        busy_hold = 1'b1;
        repeat (3) @(negedge i_Clock);
        base = rx_q.size(); ovf_base = ovf_cnt;
        write_burst(8'h40, 16);
        check("v3_full",  o_Full,  1'b1);
        check("v3_count", o_Count, 5'd16);
        @(negedge i_Clock); i_Wr_En = 1'b1; i_Wr_Byte = 8'hFF;
        @(negedge i_Clock); i_Wr_En = 1'b0;
        check("v3_ovf_on",  o_Overflow, 1'b1);
        @(negedge i_Clock);
        check("v3_ovf_off", o_Overflow, 1'b0);
        check("v3_count_k", o_Count, 5'd16);
        check("v3_ovf_cnt", ovf_cnt - ovf_base, 1);
        busy_hold = 1'b0;
        wait_rx(base + 16, "v3_rx_n");
        for (int k = 0; k < 16; k++) check("v3_rx", rx_q[base + k], 8'h40 + 8'(k));
        settle();
        check("v3_no17", rx_q.size(), base + 16);
        check("v3_empty", o_Empty, 1'b1);

        // V4: write during the pop cycle while full is rejected
        busy_hold = 1'b1;
        repeat (3) @(negedge i_Clock);
        base = rx_q.size();
        write_burst(8'h60, 16);
        check("v4_full", o_Full, 1'b1);
        busy_hold = 1'b0;
        wait_budget = 50;
        while (o_Tx_DV !== 1'b1 && wait_budget > 0) begin
            @(negedge i_Clock);
            wait_budget--;
        end
        check("v4_send_seen", o_Tx_DV, 1'b1);
        i_Wr_En = 1'b1; i_Wr_Byte = 8'hEE;
        @(negedge i_Clock); i_Wr_En = 1'b0;
        check("v4_count", o_Count, 5'd15);
        check("v4_ovf",   o_Overflow, 1'b1);
        check("v4_nfull", o_Full, 1'b0);
        wait_rx(base + 16, "v4_rx_n");
        for (int k = 0; k < 16; k++) check("v4_rx", rx_q[base + k], 8'h60 + 8'(k));
        settle();
        check("v4_no_ee", rx_q.size(), base + 16);

        // V5: 1..20 in two batches across pointer wrap
        base = rx_q.size();
        write_burst(8'd1, 10);
        wait_rx(base + 10, "v5_rx_a");
        write_burst(8'd11, 10);
        wait_rx(base + 20, "v5_rx_b");
        for (int k = 0; k < 20; k++) check("v5_rx", rx_q[base + k], 8'd1 + 8'(k));
        settle();
        check("v5_empty", o_Empty, 1'b1);
        check("v5_count", o_Count, 5'd0);

        // V6: reset mid-frame with bytes queued
        base = rx_q.size();
        write_burst(8'h31, 3);
        wait_rx(base + 1, "v6_first");
        repeat (5) @(negedge i_Clock);
        check("v6_queued", o_Count, 5'd2);
        #2 i_Reset = 1'b1;
        #1;
        check("v6_dv",    o_Tx_DV,    1'b0);
        check("v6_byte",  o_Tx_Byte,  8'h00);
        check("v6_ovf",   o_Overflow, 1'b0);
        check("v6_empty", o_Empty,    1'b1);
        check("v6_full",  o_Full,     1'b0);
        check("v6_count", o_Count,    5'd0);
        @(negedge i_Clock);
        i_Reset = 1'b0;
        dv_base = dv_cnt;
        repeat (FRAME_CYC * 4) @(negedge i_Clock);
        check("v6_no_dv", dv_cnt, dv_base);
        check("v6_rx_n",  rx_q.size(), base + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, 2..256).
REQ-002 SHALL have localparam ADDR_W = log2(DEPTH); the count is ADDR_W+1 bits.
REQ-003 SHALL have port i_Clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port i_Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_Wr_En  input  1  write request for i_Wr_Byte.
REQ-006 SHALL have port i_Wr_Byte  input  8  byte to enqueue.
REQ-007 SHALL have port o_Full  output  1  count == DEPTH.
REQ-008 SHALL have port o_Empty  output  1  count == 0.
REQ-009 SHALL have port o_Count  output  ADDR_W+1  current occupancy.
REQ-010 SHALL have port o_Overflow  output  1  one-cycle pulse on a rejected write.
REQ-011 SHALL have port o_Tx_DV  output  1  one-cycle start strobe to uart_tx.
REQ-012 SHALL have port o_Tx_Byte  output  8  byte presented to uart_tx; valid while o_Tx_DV is high.
REQ-013 SHALL have port i_Tx_Active  input  1  uart_tx is serialising.
REQ-014 SHALL have port i_Tx_Done  input  1  uart_tx end-of-frame pulse.

Function
REQ-015 SHALL store bytes in a DEPTH x 8 array with wrapping write/read pointers of ADDR_W bits and a separate count.
REQ-016 SHALL accept a write when i_Wr_En=1 and count<DEPTH; a write while full is dropped, o_Overflow pulses the next cycle, and count is unchanged.
REQ-017 SHALL not let a same-cycle pop make room for a write while full; the write is still rejected.
REQ-018 SHALL, on a simultaneous accepted write and pop, leave count unchanged and advance both pointers.
REQ-019 SHALL wrap each pointer from DEPTH-1 to 0 with no bubble.
REQ-020 SHALL implement FSM states S_IDLE, S_SEND, S_WAIT_ACT, S_WAIT_DONE and S_GAP.
REQ-021 S_IDLE SHALL move to S_SEND when count!=0 and i_Tx_Active=0.
REQ-022 S_SEND SHALL last exactly one cycle: o_Tx_DV=1, o_Tx_Byte=head entry, the read pointer advances (pop), then go to S_WAIT_ACT.
REQ-023 S_WAIT_ACT SHALL go to S_WAIT_DONE when i_Tx_Active=1, or directly to S_GAP if i_Tx_Done=1 first.
REQ-024 S_WAIT_DONE SHALL go to S_GAP on i_Tx_Done=1.
REQ-025 S_GAP SHALL last one cycle and then return to S_IDLE, absorbing the uart_tx cleanup cycle.
REQ-026 SHALL pop exactly one byte per frame, in write order.
REQ-027 SHALL hold o_Tx_Byte at the last sent value outside S_SEND, with o_Tx_DV=0.
REQ-028 SHALL give a latency from an accepted write into an empty, idle FIFO to o_Tx_DV of 2 cycles (write edge, then S_IDLE->S_SEND edge).
REQ-029 SHALL derive o_Full, o_Empty and o_Count from registered count only, with no combinational path from i_Wr_En.

Reset
REQ-030 SHALL, on i_Reset=1 and regardless of the clock, clear the pointers and count and set FSM=S_IDLE, o_Tx_DV=0, o_Tx_Byte=8'h00, o_Overflow=0, o_Empty=1, o_Full=0, o_Count=0.
REQ-031 SHALL discard queued bytes on a reset mid-frame; a frame already started in uart_tx is not aborted by this block.
REQ-032 SHALL not need the array contents reset.

Structure
REQ-033 SHALL place UART-side constants in the shared uart package: state encodings (3 bits), default DEPTH and byte width 8.
REQ-034 SHALL use a single sub-module, sync_fifo (storage, pointers, count, flags), with the FSM in uart_tx_fifo.

Verification
REQ-035 SHALL instantiate uart_tx with CLKS_PER_BIT=87 and uart_rx looped back on the serial line, using a 10-unit clock period.
REQ-036 V1: write 8'h0A at t=100 -> o_Tx_DV high 2 cycles later with o_Tx_Byte=8'h0A; uart_rx o_Rx_Byte=8'h0A about 870 cycles later.
REQ-037 V2: burst-write 8'h2D, 8'h55, 8'hAA on consecutive cycles -> uart_rx receives 2D, 55, AA in order, with exactly 3 o_Tx_DV pulses, each after i_Tx_Done plus 1 gap cycle.
REQ-038 V3: write 17 bytes with uart_tx held busy -> o_Full=1 at count 16, o_Overflow pulses once, and the 17th byte is never transmitted.
REQ-039 V4: fill to 16, then write during the S_SEND pop cycle -> write rejected, count=15 afterwards.
REQ-040 V5: pointer wrap: send 20 bytes, 1..20, in two batches of 10 -> received 1..20 in order, with o_Empty=1 at the end.
REQ-041 V6: assert i_Reset mid-frame with 3 bytes queued -> all outputs at reset values immediately, and no further o_Tx_DV after the current frame.
